// File: rtl/conv_2by2_sequencer.sv
// -----------------------------------------------------------------------------
// conv_2by2_sequencer
// Control sequencer for the 2x2 convolution datapath. A start request walks the
// datapath through a skewed 3x3-filter feed over the 4x4 input, drains the
// systolic array, then reads the four results (C11, C12, C21, C22) out of the
// result buffer in order.
//
// Ports
//   clk                 in   rising-edge clock
//   rst                 in   asynchronous reset, active-low
//   start               in   1-cycle request, honoured only when idle
//   abort               in   synchronous abort back to idle from any state
//   input_array_addr    out  5-bit select for the side (input) mux
//   filter_first_addr   out  5-bit select for the ceiling_1 mux
//   filter_second_addr  out  5-bit select for the ceiling_2 mux
//   sys_en              out  systolic array enable
//   sys_clr             out  1-cycle accumulator clear on start accept
//   buffer_read_addr    out  2-bit result buffer read select
//   out_valid           out  result output holds valid data
//   busy                out  high while a sequence is in progress
//   done                out  1-cycle pulse at the end of a sequence
//
// All outputs are registered. The outputs show the beat chosen by the state
// and beat counter of the previous cycle, so the visible sequence trails the
// internal state by one cycle; the accept cycle shows sys_clr alone.
// -----------------------------------------------------------------------------
module conv_2by2_sequencer #(
   parameter int FEED_LEN  = 10,
   parameter int DRAIN_CYC = 2,
   parameter int BUF_LAT   = 1,
   parameter int ZERO_ADDR = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic [4:0] input_array_addr,
   output logic [4:0] filter_first_addr,
   output logic [4:0] filter_second_addr,
   output logic       sys_en,
   output logic       sys_clr,
   output logic [1:0] buffer_read_addr,
   output logic       out_valid,
   output logic       busy,
   output logic       done
);

   localparam logic [4:0] ZA         = 5'(ZERO_ADDR);
   localparam logic [3:0] FEED_LAST  = 4'(FEED_LEN - 1);
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);
   localparam logic [3:0] READ_LAST  = 4'd3;
   // The last feed beat is the ceiling_2 skew beat; all earlier beats are taps.
   localparam logic [3:0] TAPS       = FEED_LAST;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FEED,
      S_DRAIN,
      S_READ,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [3:0]         r_t;
   logic [4:0]         r_in_addr;
   logic [4:0]         r_f1_addr;
   logic [4:0]         r_f2_addr;
   logic               r_sys_en;
   logic               r_sys_clr;
   logic [1:0]         r_rd_addr;
   logic               r_rd;
   logic [BUF_LAT-1:0] r_vld_dly;
   logic               r_busy;
   logic               r_done;

   // Input window row-major over the 4x4 input: 4*(t/3) + t%3.
   function automatic logic [4:0] f_in_addr(input logic [3:0] t);
      case (t)
         4'd0:    return 5'd0;
         4'd1:    return 5'd1;
         4'd2:    return 5'd2;
         4'd3:    return 5'd4;
         4'd4:    return 5'd5;
         4'd5:    return 5'd6;
         4'd6:    return 5'd8;
         4'd7:    return 5'd9;
         4'd8:    return 5'd10;
         default: return ZA;
      endcase
   endfunction

   function automatic logic [4:0] f_f1_addr(input logic [3:0] t);
      return (t < TAPS) ? (5'd16 + {1'b0, t}) : ZA;
   endfunction

   // ceiling_2 sees the same filter taps one beat later.
   function automatic logic [4:0] f_f2_addr(input logic [3:0] t);
      return (t == 4'd0) ? ZA : (5'd15 + {1'b0, t});
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_t       <= '0;
         r_in_addr <= ZA;
         r_f1_addr <= ZA;
         r_f2_addr <= ZA;
         r_sys_en  <= 1'b0;
         r_sys_clr <= 1'b0;
         r_rd_addr <= '0;
         r_rd      <= 1'b0;
         r_vld_dly <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_sys_clr    <= 1'b0;
         r_done       <= 1'b0;
         // out_valid is the read flag delayed by the buffer latency.
         r_vld_dly[0] <= r_rd;
         for (int i = 1; i < BUF_LAT; i++) begin
            r_vld_dly[i] <= r_vld_dly[i-1];
         end

         if (abort) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_in_addr <= ZA;
            r_f1_addr <= ZA;
            r_f2_addr <= ZA;
            r_sys_en  <= 1'b0;
            r_rd_addr <= '0;
            r_rd      <= 1'b0;
            r_vld_dly <= '0;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_busy <= 1'b0;
                  if (start) begin
                     r_state   <= S_FEED;
                     r_t       <= '0;
                     r_sys_clr <= 1'b1;
                     r_busy    <= 1'b1;
                  end
               end
               S_FEED: begin
                  r_sys_en  <= 1'b1;
                  r_in_addr <= f_in_addr(r_t);
                  r_f1_addr <= f_f1_addr(r_t);
                  r_f2_addr <= f_f2_addr(r_t);
                  if (r_t == FEED_LAST) begin
                     r_state <= S_DRAIN;
                     r_t     <= '0;
                  end else begin
                     r_t <= r_t + 4'd1;
                  end
               end
               S_DRAIN: begin
                  r_sys_en  <= 1'b1;
                  r_in_addr <= ZA;
                  r_f1_addr <= ZA;
                  r_f2_addr <= ZA;
                  if (r_t == DRAIN_LAST) begin
                     r_state <= S_READ;
                     r_t     <= '0;
                  end else begin
                     r_t <= r_t + 4'd1;
                  end
               end
               S_READ: begin
                  r_sys_en  <= 1'b0;
                  r_rd      <= 1'b1;
                  r_rd_addr <= r_t[1:0];
                  if (r_t == READ_LAST) begin
                     r_state <= S_DONE;
                     r_t     <= '0;
                  end else begin
                     r_t <= r_t + 4'd1;
                  end
               end
               S_DONE: begin
                  r_rd      <= 1'b0;
                  r_rd_addr <= '0;
                  r_done    <= 1'b1;
                  r_state   <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_t     <= '0;
               end
            endcase
         end
      end
   end

   assign input_array_addr   = r_in_addr;
   assign filter_first_addr  = r_f1_addr;
   assign filter_second_addr = r_f2_addr;
   assign sys_en             = r_sys_en;
   assign sys_clr            = r_sys_clr;
   assign buffer_read_addr   = r_rd_addr;
   assign out_valid          = r_vld_dly[BUF_LAT-1];
   assign busy               = r_busy;
   assign done               = r_done;

endmodule
